// File: rtl/bus_pkg.sv
// Shared widths and FSM state encoding for the serial bus target port.
package bus_pkg;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int ID_W       = 4;
    localparam int ADDR_CNT_W = $clog2(ADDR_W) + 1;
    localparam int DATA_CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        WR_WAIT,
        RD_WAIT,
        TX_DATA,
        ACK
    } state_t;
endpackage

// File: rtl/bit_serializer.sv
// Loads one data word and shifts it out LSB first on consecutive cycles.
module bit_serializer
    import bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              last
);
    logic [DATA_W-1:0]     sh;
    logic [DATA_CNT_W-1:0] cnt;
    logic                  busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            sh   <= data;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sh  <= sh >> 1;
            cnt <= cnt + DATA_CNT_W'(1);
            if (last) busy <= 1'b0;
        end
    end

    assign bit_out   = busy & sh[0];
    assign bit_valid = busy;
    assign last      = busy && (cnt == DATA_CNT_W'(DATA_W - 1));
endmodule

// File: rtl/target_port.sv
// Serial bus target: receives address/write data bit-serially, runs the device
// handshake, and returns read data bit-serially followed by an ack pulse.
module target_port
    import bus_pkg::*;
#(
    parameter logic [ID_W-1:0] TARGET_ID = 4'h1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_data_in,
    input  logic              bus_data_in_valid,
    input  logic              bus_mode,
    input  logic              bus_init_rw,
    output logic [ADDR_W-1:0] target_addr,
    output logic              target_rw,
    output logic [DATA_W-1:0] target_wr_data,
    output logic              target_wr_valid,
    output logic              target_rd_req,
    input  logic              target_ready,
    input  logic [DATA_W-1:0] target_rd_data,
    input  logic              target_rd_valid,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              target_ack,
    output logic              frame_err
);
    state_t                state, state_d;
    logic [ADDR_W-2:0]     addr_sr;
    logic [DATA_W-1:0]     wr_sr;
    logic [ADDR_CNT_W-1:0] addr_cnt;
    logic [DATA_CNT_W-1:0] data_cnt;
    logic [ADDR_W-1:0]     full_addr;
    logic                  addr_bit, data_bit, addr_last, data_last, hit;
    logic                  fe_d, ser_load, ser_last;

    assign addr_bit  = bus_data_in_valid & ~bus_mode;
    assign data_bit  = bus_data_in_valid & bus_mode;
    assign addr_last = (addr_cnt == ADDR_CNT_W'(ADDR_W - 1));
    assign data_last = (data_cnt == DATA_CNT_W'(DATA_W - 1));
    // The 16th bit is still on the wire, so decode from the shift register plus it.
    assign full_addr = {bus_data_in, addr_sr};
    assign hit       = (full_addr[ADDR_W-1 -: ID_W] == TARGET_ID);
    assign ser_load  = (state == RD_WAIT) & target_rd_valid;

    always_comb begin
        state_d = state;
        fe_d    = 1'b0;
        unique case (state)
            IDLE:    if (addr_bit) state_d = RX_ADDR;
            RX_ADDR: begin
                if (data_bit) begin
                    fe_d    = 1'b1;
                    state_d = IDLE;
                end else if (addr_bit && addr_last) begin
                    if (!hit)             state_d = IDLE;
                    else if (bus_init_rw) state_d = RX_DATA;
                    else                  state_d = RD_WAIT;
                end
            end
            RX_DATA: begin
                if (addr_bit) begin
                    fe_d    = 1'b1;
                    state_d = IDLE;
                end else if (data_bit && data_last) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: if (target_ready)    state_d = ACK;
            RD_WAIT: if (target_rd_valid) state_d = TX_DATA;
            TX_DATA: if (ser_last)        state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_sr     <= '0;
            wr_sr       <= '0;
            addr_cnt    <= '0;
            data_cnt    <= '0;
            target_addr <= '0;
            target_rw   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state     <= state_d;
            frame_err <= fe_d;
            if (state_d == IDLE) begin
                addr_cnt <= '0;
                data_cnt <= '0;
            end else begin
                if (addr_bit && (state == IDLE || state == RX_ADDR)) begin
                    addr_sr  <= {bus_data_in, addr_sr[ADDR_W-2:1]};
                    addr_cnt <= addr_cnt + ADDR_CNT_W'(1);
                end
                if (data_bit && state == RX_DATA) begin
                    wr_sr    <= {bus_data_in, wr_sr[DATA_W-1:1]};
                    data_cnt <= data_cnt + DATA_CNT_W'(1);
                end
            end
            // Only a decoded hit publishes address and direction to the device.
            if (state == RX_ADDR && addr_bit && addr_last && hit) begin
                target_addr <= full_addr;
                target_rw   <= bus_init_rw;
            end
        end
    end

    assign target_wr_data  = wr_sr;
    assign target_wr_valid = (state == WR_WAIT);
    assign target_rd_req   = (state == RD_WAIT);
    assign target_ack      = (state == ACK);

    bit_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .data      (target_rd_data),
        .bit_out   (bus_data_out),
        .bit_valid (bus_data_out_valid),
        .last      (ser_last)
    );
endmodule

// File: tb/tb_target_port.sv
// Self-checking bench for target_port: directed vector table, multi-cycle corner
// sequences and randomized transactions against a transaction-level model.
module tb_target_port;
    import bus_pkg::*;

    localparam logic [3:0] TID = 4'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_data_in, bus_data_in_valid, bus_mode, bus_init_rw;
    logic [15:0] target_addr;
    logic        target_rw;
    logic [7:0]  target_wr_data;
    logic        target_wr_valid, target_rd_req, target_ready;
    logic [7:0]  target_rd_data;
    logic        target_rd_valid;
    logic        bus_data_out, bus_data_out_valid, target_ack, frame_err;

    always #5 clk = ~clk;

    target_port #(.TARGET_ID(TID)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus_data_in       (bus_data_in),
        .bus_data_in_valid (bus_data_in_valid),
        .bus_mode          (bus_mode),
        .bus_init_rw       (bus_init_rw),
        .target_addr       (target_addr),
        .target_rw         (target_rw),
        .target_wr_data    (target_wr_data),
        .target_wr_valid   (target_wr_valid),
        .target_rd_req     (target_rd_req),
        .target_ready      (target_ready),
        .target_rd_data    (target_rd_data),
        .target_rd_valid   (target_rd_valid),
        .bus_data_out      (bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .target_ack        (target_ack),
        .frame_err         (frame_err)
    );

    int n_cmp = 0, n_fail = 0;
    int ack_cnt = 0, fe_cnt = 0;

    always @(negedge clk) begin
        if (target_ack) ack_cnt++;
        if (frame_err)  fe_cnt++;
    end

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        int          dly;
        int          gap;
        int          exp_ack;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus_data_in_valid = 1'b0;
        bus_mode          = 1'b0;
        bus_data_in       = 1'b0;
    endtask

    task automatic junk();
        bus_data_in_valid = 1'($urandom);
        bus_mode          = 1'($urandom);
        bus_data_in       = 1'($urandom);
    endtask

    task automatic send_bit(input logic b, input logic m, input logic rw, input int gap);
        repeat ($urandom_range(gap, 0)) begin
            bus_data_in_valid = 1'b0;
            bus_mode          = 1'($urandom);
            bus_data_in       = 1'($urandom);
            step();
        end
        bus_data_in       = b;
        bus_mode          = m;
        bus_init_rw       = rw;
        bus_data_in_valid = 1'b1;
        step();
        bus_data_in_valid = 1'b0;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw, input int gap);
        for (int i = 0; i < 16; i++)
            send_bit(a[i], 1'b0, (i == 15) ? rw : 1'($urandom), gap);
    endtask

    task automatic send_data(input logic [7:0] d, input int gap);
        for (int i = 0; i < 8; i++)
            send_bit(d[i], 1'b1, 1'($urandom), gap);
    endtask

    task automatic run_txn(input vec_t v);
        int a0, cnt;
        bit m;
        a0 = ack_cnt;
        m  = (v.addr[15:12] == TID);
        send_addr(v.addr, v.rw, v.gap);
        if (v.rw) send_data(v.data, v.gap);
        if (m && v.rw) begin
            cnt = 0;
            while (target_wr_valid && cnt < 32) begin
                cnt++;
                chk("wr_addr", target_addr, v.addr);
                chk("wr_data", target_wr_data, v.data);
                target_ready = (cnt == v.dly);
                junk();
                step();
            end
            target_ready = 1'b0;
            quiet();
            chk("wr_valid_cycles", cnt, v.dly);
            chk("wr_rw", target_rw, 1'b1);
            chk("wr_ack", target_ack, 1'b1);
            step();
        end else if (m) begin
            cnt = 0;
            chk("rd_addr", target_addr, v.addr);
            chk("rd_rw", target_rw, 1'b0);
            while (target_rd_req && cnt < 32) begin
                cnt++;
                if (cnt == v.dly) begin
                    target_rd_valid = 1'b1;
                    target_rd_data  = v.data;
                end
                target_ready = 1'($urandom);
                junk();
                step();
                target_rd_valid = 1'b0;
                target_rd_data  = 8'($urandom);
            end
            chk("rd_req_cycles", cnt, v.dly);
            for (int i = 0; i < 8; i++) begin
                chk("rd_ser_vld", bus_data_out_valid, 1'b1);
                chk("rd_ser_bit", bus_data_out, v.data[i]);
                target_rd_valid = 1'($urandom);
                junk();
                step();
            end
            target_rd_valid = 1'b0;
            target_ready    = 1'b0;
            quiet();
            chk("rd_ser_end", bus_data_out_valid, 1'b0);
            chk("rd_ack", target_ack, 1'b1);
            step();
        end else begin
            repeat (4) begin
                chk("miss_quiet", {target_wr_valid, target_rd_req, target_ack, bus_data_out_valid}, 4'h0);
                step();
            end
        end
        chk("ack_gone", target_ack, 1'b0);
        chk("ack_count", ack_cnt - a0, v.exp_ack);
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, target_wr_valid, target_rd_req, target_ack, bus_data_out_valid,
                frame_err, target_rw, bus_data_out, target_addr, target_wr_data};
    endfunction

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, f0;
        vec_t rv;

        vecs[0] = '{16'h1234, 1'b1, 8'hA5, 3, 0, 1};
        vecs[1] = '{16'h1ABC, 1'b0, 8'h3C, 5, 0, 1};
        vecs[2] = '{16'h2000, 1'b1, 8'hFF, 1, 0, 0};
        vecs[3] = '{16'h1FFF, 1'b1, 8'h00, 1, 2, 1};
        vecs[4] = '{16'h1001, 1'b0, 8'h81, 1, 3, 1};
        vecs[5] = '{16'hF123, 1'b0, 8'h55, 2, 0, 0};
        vecs[6] = '{16'h1234, 1'b1, 8'h5A, 2, 3, 1};

        rst_n = 1'b0;
        quiet();
        bus_init_rw     = 1'b0;
        target_ready    = 1'b0;
        target_rd_valid = 1'b0;
        target_rd_data  = 8'h00;
        #1;
        chk("reset_outs", all_outs(), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_outs", all_outs(), 32'h0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // Data-mode bit after 7 address bits.
        f0 = fe_cnt;
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0, 1'b0, 1);
        send_bit(1'b1, 1'b1, 1'b0, 0);
        chk("fe_addr_pulse", frame_err, 1'b1);
        step();
        chk("fe_addr_drop", frame_err, 1'b0);
        chk("fe_addr_count", fe_cnt - f0, 1);
        run_txn('{16'h1234, 1'b1, 8'h96, 1, 0, 1});

        // Address-mode bit in the middle of write data.
        f0 = fe_cnt;
        send_addr(16'h1777, 1'b1, 0);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 1'b0, 0);
        chk("fe_data_pulse", frame_err, 1'b1);
        step();
        chk("fe_data_count", fe_cnt - f0, 1);
        chk("fe_data_no_wr", target_wr_valid, 1'b0);
        run_txn('{16'h1C0D, 1'b0, 8'hE7, 2, 1, 1});

        // Reset while the write handshake is pending.
        send_addr(16'h1234, 1'b1, 0);
        send_data(8'hC3, 0);
        chk("pre_rst_wr_valid", target_wr_valid, 1'b1);
        step();
        step();
        a0 = ack_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_async", all_outs(), 32'h0);
        target_ready = 1'b1;
        step();
        chk("rst_wr_edge", all_outs(), 32'h0);
        rst_n = 1'b1;
        repeat (4) begin
            chk("rst_wr_after", {target_wr_valid, target_ack}, 2'b00);
            step();
        end
        target_ready = 1'b0;
        chk("rst_wr_no_ack", ack_cnt - a0, 0);

        // Reset while read data is being shifted out.
        send_addr(16'h1ABC, 1'b0, 0);
        target_rd_data  = 8'hFF;
        target_rd_valid = 1'b1;
        step();
        target_rd_valid = 1'b0;
        step();
        step();
        chk("pre_rst_tx_vld", bus_data_out_valid, 1'b1);
        a0 = ack_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_async", all_outs(), 32'h0);
        step();
        rst_n = 1'b1;
        target_rd_valid = 1'b1;
        repeat (10) begin
            chk("rst_tx_after", {bus_data_out_valid, target_ack, target_rd_req}, 3'b000);
            step();
        end
        target_rd_valid = 1'b0;
        chk("rst_tx_no_ack", ack_cnt - a0, 0);

        // Randomized transactions against the transaction-level model.
        for (int t = 0; t < 16; t++) begin
            rv.addr    = {($urandom_range(1, 0) == 1) ? TID : 4'($urandom), 12'($urandom)};
            rv.rw      = 1'($urandom);
            rv.data    = 8'($urandom);
            rv.dly     = int'($urandom_range(4, 1));
            rv.gap     = int'($urandom_range(2, 0));
            rv.exp_ack = (rv.addr[15:12] == TID) ? 1 : 0;
            run_txn(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/target_port.md
TARGET_PORT -- requirements
Module: target_port

Interface
REQ-001 Parameter TARGET_ID, default 4'h1, address-decode value compared against addr[15:12].
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 bus_data_in  input  1  serial bit from initiator port, LSB first.
REQ-005 bus_data_in_valid  input  1  qualifies bus_data_in for one cycle.
REQ-006 bus_mode  input  1  1 = data bit, 0 = address bit.
REQ-007 bus_init_rw  input  1  1 = write, 0 = read; sampled with the 16th address bit.
REQ-008 target_addr  output  16  decoded transaction address.
REQ-009 target_rw  output  1  registered rw of current transaction.
REQ-010 target_wr_data  output  8  write data to device.
REQ-011 target_wr_valid  output  1  write request, held until target_ready.
REQ-012 target_rd_req  output  1  read request, held until target_rd_valid.
REQ-013 target_ready  input  1  device accepts write.
REQ-014 target_rd_data  input  8  device read data.
REQ-015 target_rd_valid  input  1  target_rd_data valid, one cycle.
REQ-016 bus_data_out  output  1  serial read-data bit to initiator, LSB first.
REQ-017 bus_data_out_valid  output  1  qualifies bus_data_out.
REQ-018 target_ack  output  1  one-cycle completion pulse.
REQ-019 frame_err  output  1  one-cycle framing-error pulse.

Function
REQ-020 FSM states SHALL be IDLE, RX_ADDR, RX_DATA, WR_WAIT, RD_WAIT, TX_DATA, ACK.
REQ-021 Bits SHALL be counted only in cycles where bus_data_in_valid=1; gaps of any length are legal.
REQ-022 IDLE: valid bit with bus_mode=0 -> store as addr[0], count=1, go RX_ADDR; bits with bus_mode=1 ignored.
REQ-023 RX_ADDR: shift bits into addr[count]; on 16th bit capture bus_init_rw; valid bit with bus_mode=1 -> frame_err pulse, go IDLE.
REQ-024 After 16th bit: addr[15:12]!=TARGET_ID -> IDLE, no ack, no outputs asserted; match & rw=1 -> RX_DATA; match & rw=0 -> RD_WAIT with target_rd_req=1 next cycle.
REQ-025 RX_DATA: 8 bits with bus_mode=1 into wr_data LSB first; valid bit with bus_mode=0 -> frame_err, IDLE; after 8th bit -> WR_WAIT, target_wr_valid=1 next cycle.
REQ-026 WR_WAIT: hold target_wr_valid, target_addr, target_wr_data stable; target_ready=1 completes handshake that cycle, go ACK.
REQ-027 RD_WAIT: hold target_rd_req; on target_rd_valid capture data, drop req next cycle, go TX_DATA.
REQ-028 TX_DATA: drive 8 consecutive cycles of bus_data_out_valid=1, bit i in i-th cycle, no gaps; then ACK.
REQ-029 ACK: target_ack=1 for exactly one cycle, then IDLE.
REQ-030 Incoming bus bits during WR_WAIT, RD_WAIT, TX_DATA, ACK SHALL be ignored.
REQ-031 target_ready or target_rd_valid outside their wait states SHALL be ignored.
REQ-032 Bit counters SHALL be sized exactly (5 bits address, 3 bits data) and cleared on every IDLE entry.

Reset
REQ-033 rst_n low SHALL force IDLE and zero every output, counter and shift register, including mid-transaction.
REQ-034 No handshake started before reset SHALL complete or ack after reset release.

Structure
REQ-035 Shared package bus_pkg SHALL hold state enum, ADDR_W=16, DATA_W=8, ID_W=4.
REQ-036 Read serializer SHALL be sub-module bit_serializer (load 8 bits, shift out with valid).

Verification
REQ-037 Write 16'h1234, data 8'hA5, target_ready after 3 cycles -> wr_valid held 3 cycles, target_wr_data=A5, one ack.
REQ-038 Read 16'h1ABC, device returns 8'h3C after 5 cycles -> serial out 0,0,1,1,1,1,0,0 contiguous, then ack.
REQ-039 Write 16'h2000 with TARGET_ID=1 -> no wr_valid, no ack, following data bits ignored.
REQ-040 Data-mode bit after 7 address bits -> frame_err pulse, IDLE, next valid transaction succeeds.
REQ-041 Address bits with random valid gaps -> same addr as gap-free case.
REQ-042 rst_n asserted during WR_WAIT and during TX_DATA -> all outputs 0 next edge, no ack after release.
